// File: rtl/ppu_timing_pkg.sv
// Default PPU video timing constants (NTSC-like SNES values) and the shared
// 9-bit dot/line count type used by the timing generator and its counter.
package ppu_timing_pkg;

   typedef logic [8:0] count_t;

   localparam int unsigned H_TOTAL_DEF      = 341;
   localparam int unsigned V_TOTAL_DEF      = 262;
   localparam int unsigned HSYNC_LEN_DEF    = 25;
   localparam int unsigned BURST_START_DEF  = 28;
   localparam int unsigned BURST_LEN_DEF    = 12;
   localparam int unsigned HBLANK_START_DEF = 274;
   localparam int unsigned HBLANK_END_DEF   = 22;
   localparam int unsigned VBLANK_START_DEF = 225;
   localparam int unsigned VSYNC_START_DEF  = 240;
   localparam int unsigned VSYNC_LEN_DEF    = 3;

endpackage

// File: rtl/ppu_dot_line_counter.sv
// Free-running dot (h) and line (v) counter. Advances one dot per enabled
// cycle; the line counter steps when the dot counter wraps.
module ppu_dot_line_counter
   import ppu_timing_pkg::*;
#(
   parameter int unsigned H_TOTAL = H_TOTAL_DEF,
   parameter int unsigned V_TOTAL = V_TOTAL_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   output logic [8:0] h_count,
   output logic [8:0] v_count
);

   localparam count_t H_LAST = count_t'(H_TOTAL - 1);
   localparam count_t V_LAST = count_t'(V_TOTAL - 1);

   // Step the dot counter, carrying into the line counter at end of line and
   // wrapping the line counter at end of frame; reset is active low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (enable) begin
         if (h_count == H_LAST) begin
            h_count <= '0;
            if (v_count == V_LAST) begin
               v_count <= '0;
            end else begin
               v_count <= v_count + 9'd1;
            end
         end else begin
            h_count <= h_count + 9'd1;
         end
      end
   end

endmodule

// File: rtl/ppu_timing_gen.sv
// PPU video timing generator: decodes burst, composite sync and blanking from
// the dot/line counter and registers them, so every decoded output trails the
// counter value it was derived from by one enabled cycle.
module ppu_timing_gen
   import ppu_timing_pkg::*;
#(
   parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
   parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
   parameter int unsigned HSYNC_LEN    = HSYNC_LEN_DEF,
   parameter int unsigned BURST_START  = BURST_START_DEF,
   parameter int unsigned BURST_LEN    = BURST_LEN_DEF,
   parameter int unsigned HBLANK_START = HBLANK_START_DEF,
   parameter int unsigned HBLANK_END   = HBLANK_END_DEF,
   parameter int unsigned VBLANK_START = VBLANK_START_DEF,
   parameter int unsigned VSYNC_START  = VSYNC_START_DEF,
   parameter int unsigned VSYNC_LEN    = VSYNC_LEN_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable_i,
   output logic       burst_n,
   output logic       csync_n,
   output logic       hblank,
   output logic       vblank,
   output logic       frame_start_o,
   output logic [8:0] h_count_o,
   output logic [8:0] v_count_o
);

   // Reject illegal timing at elaboration: ranges must sit inside the totals
   // and the hblank window must wrap through dot 0.
   if (!(H_TOTAL <= 512 && V_TOTAL <= 512 &&
         HSYNC_LEN <= H_TOTAL &&
         BURST_START + BURST_LEN <= H_TOTAL &&
         HBLANK_START < H_TOTAL && HBLANK_END < HBLANK_START &&
         VBLANK_START < V_TOTAL &&
         VSYNC_START + VSYNC_LEN <= V_TOTAL)) begin : g_bad_params
      $fatal(1, "ppu_timing_gen: illegal timing parameters");
   end

   // Compare bounds are widened to 10 bits so start+length sums never wrap.
   localparam logic [9:0] HS_END   = 10'(HSYNC_LEN);
   localparam logic [9:0] BS_START = 10'(BURST_START);
   localparam logic [9:0] BS_END   = 10'(BURST_START + BURST_LEN);
   localparam logic [9:0] HB_START = 10'(HBLANK_START);
   localparam logic [9:0] HB_END   = 10'(HBLANK_END);
   localparam logic [9:0] VB_START = 10'(VBLANK_START);
   localparam logic [9:0] VS_START = 10'(VSYNC_START);
   localparam logic [9:0] VS_END   = 10'(VSYNC_START + VSYNC_LEN);

   logic [8:0] h_count;
   logic [8:0] v_count;
   logic [9:0] h_wide;
   logic [9:0] v_wide;
   logic       hs;
   logic       vs;
   logic       csync_d;
   logic       burst_d;
   logic       hblank_d;
   logic       vblank_d;
   logic       frame_start_d;

   ppu_dot_line_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_counter (
      .clock   (clock),
      .reset   (reset),
      .enable  (enable_i),
      .h_count (h_count),
      .v_count (v_count)
   );

   assign h_count_o = h_count;
   assign v_count_o = v_count;

   // Pure decode of the current (h, v); csync is serrated on vsync lines and
   // burst is suppressed there.
   always_comb begin
      h_wide        = {1'b0, h_count};
      v_wide        = {1'b0, v_count};
      hs            = (h_wide < HS_END);
      vs            = (v_wide >= VS_START) && (v_wide < VS_END);
      csync_d       = vs ? !hs : hs;
      burst_d       = (h_wide >= BS_START) && (h_wide < BS_END) && !vs;
      hblank_d      = (h_wide >= HB_START) || (h_wide < HB_END);
      vblank_d      = (v_wide >= VB_START);
      frame_start_d = (h_count == 9'd0) && (v_count == 9'd0);
   end

   // Register the decode on enabled cycles only, so a paused generator holds
   // every output (including frame_start_o) exactly where it was.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         burst_n       <= 1'b1;
         csync_n       <= 1'b1;
         hblank        <= 1'b0;
         vblank        <= 1'b0;
         frame_start_o <= 1'b0;
      end else if (enable_i) begin
         burst_n       <= !burst_d;
         csync_n       <= !csync_d;
         hblank        <= hblank_d;
         vblank        <= vblank_d;
         frame_start_o <= frame_start_d;
      end
   end

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Scoreboard bench for ppu_timing_gen using a 16-dot x 8-line frame. The
// driver pushes the expected registered outputs for each clock edge; a
// monitor pops and compares them on the falling edge.
module tb_ppu_timing_gen;

   typedef struct packed {
      logic       burst_n;
      logic       csync_n;
      logic       hblank;
      logic       vblank;
      logic       frame_start;
      logic [8:0] h;
      logic [8:0] v;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable_i;
   logic       burst_n;
   logic       csync_n;
   logic       hblank;
   logic       vblank;
   logic       frame_start_o;
   logic [8:0] h_count_o;
   logic [8:0] v_count_o;

   exp_t exp_q[$];
   exp_t last_exp;
   int   n_compared   = 0;
   int   n_mismatched = 0;
   int   model_h      = 0;
   int   model_v      = 0;

   // Hand-derived per-dot patterns for the small frame (bit index = dot/line).
   logic [15:0] csync_norm_mask = 16'b1111_1111_1111_1100;
   logic [15:0] csync_vs_mask   = 16'b0000_0000_0000_0011;
   logic [15:0] burst_norm_mask = 16'b1111_1111_1110_0111;
   logic [15:0] hblank_mask     = 16'b1111_0000_0000_0001;
   logic [7:0]  vblank_mask     = 8'b1110_0000;

   ppu_timing_gen #(
      .H_TOTAL      (16),
      .V_TOTAL      (8),
      .HSYNC_LEN    (2),
      .BURST_START  (3),
      .BURST_LEN    (2),
      .HBLANK_START (12),
      .HBLANK_END   (1),
      .VBLANK_START (5),
      .VSYNC_START  (6),
      .VSYNC_LEN    (1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .enable_i      (enable_i),
      .burst_n       (burst_n),
      .csync_n       (csync_n),
      .hblank        (hblank),
      .vblank        (vblank),
      .frame_start_o (frame_start_o),
      .h_count_o     (h_count_o),
      .v_count_o     (v_count_o)
   );

   // 10-unit clock period.
   always #5 clock = ~clock;

   function automatic exp_t reset_expect();
      exp_t e;
      e.burst_n     = 1'b1;
      e.csync_n     = 1'b1;
      e.hblank      = 1'b0;
      e.vblank      = 1'b0;
      e.frame_start = 1'b0;
      e.h           = 9'd0;
      e.v           = 9'd0;
      return e;
   endfunction

   function automatic exp_t decode_expect(input int h, input int v, input int nh, input int nv);
      exp_t e;
      logic vs_line;
      vs_line       = (v == 6);
      e.csync_n     = vs_line ? csync_vs_mask[h] : csync_norm_mask[h];
      e.burst_n     = vs_line ? 1'b1 : burst_norm_mask[h];
      e.hblank      = hblank_mask[h];
      e.vblank      = vblank_mask[v];
      e.frame_start = (h == 0) && (v == 0);
      e.h           = 9'(nh);
      e.v           = 9'(nv);
      return e;
   endfunction

   // One clock with the given enable; pushes what the outputs should be after it.
   task automatic apply_stimulus(input logic en);
      exp_t e;
      int   nh;
      int   nv;
      enable_i = en;
      @(posedge clock);
      if (en) begin
         nh = model_h + 1;
         nv = model_v;
         if (nh == 16) begin
            nh = 0;
            nv = model_v + 1;
            if (nv == 8) nv = 0;
         end
         e       = decode_expect(model_h, model_v, nh, nv);
         model_h = nh;
         model_v = nv;
      end else begin
         e = last_exp;
      end
      last_exp = e;
      exp_q.push_back(e);
      @(negedge clock);
   endtask

   task automatic reset_cycle(input logic en);
      exp_t e;
      reset    = 1'b0;
      enable_i = en;
      @(posedge clock);
      e        = reset_expect();
      model_h  = 0;
      model_v  = 0;
      last_exp = e;
      exp_q.push_back(e);
      @(negedge clock);
   endtask

   // Assert reset shortly after an edge; the falling-edge check lands before
   // the next rising edge, so only an asynchronous reset can satisfy it.
   task automatic reset_mid();
      exp_t e;
      enable_i = 1'b1;
      @(posedge clock);
      #2 reset = 1'b0;
      e        = reset_expect();
      model_h  = 0;
      model_v  = 0;
      last_exp = e;
      exp_q.push_back(e);
      @(negedge clock);
   endtask

   task automatic check_field(input string name, input logic [8:0] act, input logic [8:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatched++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   task automatic check_output(input exp_t e);
      check_field("burst_n",       9'(burst_n),       9'(e.burst_n));
      check_field("csync_n",       9'(csync_n),       9'(e.csync_n));
      check_field("hblank",        9'(hblank),        9'(e.hblank));
      check_field("vblank",        9'(vblank),        9'(e.vblank));
      check_field("frame_start_o", 9'(frame_start_o), 9'(e.frame_start));
      check_field("h_count_o",     h_count_o,         e.h);
      check_field("v_count_o",     v_count_o,         e.v);
   endtask

   // Monitor: compare each pending expectation on the falling edge.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_output(e);
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence: reset, two full frames, a mid-line pause, then a
   // mid-frame reset at line 3 dot 9 followed by a fresh start.
   initial begin
      reset    = 1'b0;
      enable_i = 1'b0;
      last_exp = reset_expect();
      @(negedge clock);
      repeat (3) reset_cycle(1'b0);
      reset = 1'b1;
      repeat (256) apply_stimulus(1'b1);
      repeat (7) apply_stimulus(1'b1);
      repeat (10) apply_stimulus(1'b0);
      repeat (5) apply_stimulus(1'b1);
      for (int i = 0; i < 200 && !(model_h == 8 && model_v == 3); i++) begin
         apply_stimulus(1'b1);
      end
      reset_mid();
      reset_cycle(1'b1);
      reset = 1'b1;
      repeat (40) apply_stimulus(1'b1);
      repeat (3) @(negedge clock);
      if (exp_q.size() != 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
